// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, S-box table and GF(2^8) helpers.
// Used by aes_round_core and aes_cipher_ctrl.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  function automatic int nr_from_nk(input int nk);
    return nk + 6;
  endfunction

  // Entry 0x00 sits in the top byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // ~b * 8 selects entry b counted from the top.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_cipher_ctrl_if.sv
// aes_cipher_ctrl_if: block-in / ciphertext-out valid/ready bundle.
// master = block source + ciphertext sink, slave = controller.
interface aes_cipher_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plainText;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] encryptedText;

  modport master (
    output in_valid, plainText, out_ready,
    input  in_ready, out_valid, encryptedText
  );

  modport slave (
    input  in_valid, plainText, out_ready,
    output in_ready, out_valid, encryptedText
  );
endinterface

// File: rtl/aes_round_core.sv
// aes_round_core: one combinational AES round, MixColumns bypassed on final.
// Ports: i_state, i_round_key, i_final -> o_state.
module aes_round_core
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_round_key,
  input  logic         i_final,
  output logic [127:0] o_state
);
  logic [7:0] w_sb [16];
  logic [7:0] w_sr [16];
  logic [7:0] w_mc [16];

  // Byte i = row (i%4), column (i/4); byte 0 in the top bits.
  for (genvar i = 0; i < 16; i++) begin : g_byte
    localparam int C = i / 4;
    localparam int R = i % 4;
    assign w_sb[i] = sbox(i_state[127-8*i -: 8]);
    assign w_sr[i] = w_sb[R + 4*((C + R) % 4)];
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = w_sr[4*c];
    assign a1 = w_sr[4*c+1];
    assign a2 = w_sr[4*c+2];
    assign a3 = w_sr[4*c+3];
    assign w_mc[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign w_mc[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign w_mc[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign w_mc[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

  for (genvar i = 0; i < 16; i++) begin : g_ark
    assign o_state[127-8*i -: 8] =
      (i_final ? w_sr[i] : w_mc[i]) ^ i_round_key[127-8*i -: 8];
  end
endmodule

// File: rtl/aes_cipher_ctrl.sv
// aes_cipher_ctrl: iterative AES encryptor, one round per clock.
// Ports: clk, rst_n, bus (slave), keys, busy, round.
module aes_cipher_ctrl
  import aes_pkg::*;
#(
  parameter  int Nk = 4,
  localparam int Nr = nr_from_nk(Nk)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  aes_cipher_ctrl_if.slave      bus,
  input  logic [128*(Nr+1)-1:0] keys,
  output logic                  busy,
  output logic [3:0]            round
);
  localparam logic [3:0] LAST = 4'(Nr);

  state_e       r_fsm;
  state_e       w_nxt;
  logic [127:0] r_state;
  logic [3:0]   r_round;
  logic [127:0] w_rk [Nr+1];
  logic [127:0] w_rnd;
  logic         w_last;
  logic         w_in_ready;
  logic         w_out_valid;
  logic         w_busy;

  for (genvar r = 0; r <= Nr; r++) begin : g_rk
    assign w_rk[r] = keys[128*r +: 128];
  end

  assign w_last = (r_round == LAST);

  aes_round_core u_core (
    .i_state     (r_state),
    .i_round_key (w_rk[r_round]),
    .i_final     (w_last),
    .o_state     (w_rnd)
  );

  always_comb begin
    w_nxt       = r_fsm;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    unique case (r_fsm)
      IDLE: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b0;
        if (bus.in_valid) w_nxt = RUN;
      end
      RUN: begin
        if (w_last) w_nxt = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm   <= IDLE;
      r_state <= '0;
      r_round <= '0;
    end else begin
      r_fsm <= w_nxt;
      unique case (r_fsm)
        IDLE: begin
          if (bus.in_valid) begin
            r_state <= bus.plainText ^ w_rk[0];
            r_round <= 4'd1;
          end
        end
        RUN: begin
          r_state <= w_rnd;
          // Hold at Nr through DONE.
          if (!w_last) r_round <= r_round + 4'd1;
        end
        DONE: begin
          if (bus.out_ready) r_round <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready      = w_in_ready;
  assign bus.out_valid     = w_out_valid;
  assign bus.encryptedText = r_state;
  assign busy              = w_busy;
  assign round             = r_round;
endmodule

// File: tb/tb_aes_cipher_ctrl.sv
// tb_aes_cipher_ctrl: directed bench with scoreboard and reference model.
// Drives an Nk=4 and an Nk=8 instance of aes_cipher_ctrl.
module tb_aes_cipher_ctrl;
  logic clk;
  logic rst_n;

  aes_cipher_ctrl_if bus4();
  aes_cipher_ctrl_if bus8();

  logic [128*11-1:0] keys4;
  logic [128*15-1:0] keys8;
  logic [128*15-1:0] kt4;
  logic              busy4, busy8;
  logic [3:0]        round4, round8;

  aes_cipher_ctrl #(.Nk(4)) u4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4),
    .keys  (keys4),
    .busy  (busy4),
    .round (round4)
  );

  aes_cipher_ctrl #(.Nk(8)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8),
    .keys  (keys8),
    .busy  (busy8),
    .round (round8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc      = 0;
  logic [127:0] sb_q [$];
  logic [7:0]   sb [256];

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Independent GF(2^8) model: shift-and-add multiply, S-box from inverse.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v};
    return d[15-n -: 8];
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = '0;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
            ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [128*15-1:0] kexp(input logic [255:0] key,
                                             input int nk);
    logic [31:0]       w [60];
    logic [31:0]       t;
    logic [7:0]        rc;
    logic [128*15-1:0] k;
    int                nr;
    nr = nk + 6;
    rc = 8'h01;
    k  = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++)
      k[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return k;
  endfunction

  function automatic logic [127:0] ref_enc(input logic [127:0] pt,
                                           input logic [128*15-1:0] k,
                                           input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a [4];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) s[w+4*c] = t[w + 4*((c+w) % 4)];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int w = 0; w < 4; w++) a[w] = s[4*c+w];
          for (int w = 0; w < 4; w++)
            s[4*c+w] = gm(a[w], 8'h02) ^ gm(a[(w+1)%4], 8'h03)
                     ^ a[(w+2)%4] ^ a[(w+3)%4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[128*r+127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic ov(input int w);
    return (w == 8) ? bus8.out_valid : bus4.out_valid;
  endfunction

  function automatic logic ir(input int w);
    return (w == 8) ? bus8.in_ready : bus4.in_ready;
  endfunction

  function automatic logic [127:0] ct(input int w);
    return (w == 8) ? bus8.encryptedText : bus4.encryptedText;
  endfunction

  task automatic drive(input int w, input logic v, input logic [127:0] p);
    if (w == 8) begin
      bus8.in_valid  = v;
      bus8.plainText = p;
    end else begin
      bus4.in_valid  = v;
      bus4.plainText = p;
    end
  endtask

  // Presents a block, waits for the acceptance edge, records the expectation.
  task automatic accept(input int w, input logic [127:0] p,
                        input logic [127:0] exp);
    int n;
    n = 0;
    drive(w, 1'b1, p);
    while (!ir(w) && n < 40) begin
      step();
      n++;
    end
    step();
    acc = cyc;
    sb_q.push_back(exp);
    drive(w, 1'b0, '0);
  endtask

  // Waits for out_valid; checks latency from acceptance and the ciphertext.
  task automatic wait_out(input int w, input int nr, input string tag,
                          output logic [127:0] e);
    while (!ov(w) && (cyc - acc) < 40) step();
    chk({tag, "_lat"}, 128'(cyc - acc), 128'(nr));
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
    chk({tag, "_ct"}, ct(4'(w) == 4'd8 ? 8 : 4), e);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"},  128'(bus4.in_ready),      128'd1);
    chk({tag, "_out_valid"}, 128'(bus4.out_valid),     128'd0);
    chk({tag, "_busy"},      128'(busy4),              128'd0);
    chk({tag, "_round"},     128'(round4),             128'd0);
    chk({tag, "_ct"},        bus4.encryptedText,       128'd0);
  endtask

  logic [127:0] e, p, pa, pb;
  int           n;

  initial begin
    rst_n          = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.plainText = '0;
    bus4.out_ready = 1'b0;
    bus8.in_valid  = 1'b0;
    bus8.plainText = '0;
    bus8.out_ready = 1'b0;
    build_sbox();
    kt4   = kexp({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    keys4 = kt4[128*11-1:0];
    keys8 = kexp(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

    #12;
    chk_idle("reset");
    rst_n = 1'b1;
    step();
    step();

    // FIPS-197 C.1
    bus4.out_ready = 1'b1;
    accept(4, PT, C1);
    chk("c1_busy",     128'(busy4),         128'd1);
    chk("c1_round1",   128'(round4),        128'd1);
    chk("c1_in_ready", 128'(bus4.in_ready), 128'd0);
    wait_out(4, 10, "c1", e);
    chk("c1_round_nr", 128'(round4), 128'd10);
    step();
    chk("c1_ready_back", 128'(bus4.in_ready),  128'd1);
    chk("c1_ov_low",     128'(bus4.out_valid), 128'd0);

    // FIPS-197 C.3
    bus8.out_ready = 1'b1;
    accept(8, PT, C3);
    wait_out(8, 14, "c3", e);
    chk("c3_round_nr", 128'(round8), 128'd14);
    step();
    chk("c3_ready_back", 128'(bus8.in_ready), 128'd1);

    // Backpressure
    bus4.out_ready = 1'b0;
    p = rnd128();
    accept(4, p, ref_enc(p, kt4, 10));
    wait_out(4, 10, "bp", e);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold_ov",  128'(bus4.out_valid), 128'd1);
      chk("bp_hold_ct",  bus4.encryptedText,   e);
      chk("bp_hold_rdy", 128'(bus4.in_ready),  128'd0);
    end
    bus4.out_ready = 1'b1;
    step();
    chk("bp_release_rdy", 128'(bus4.in_ready), 128'd1);

    // Second block presented while busy, then held until taken
    pa = rnd128();
    pb = rnd128();
    accept(4, pa, ref_enc(pa, kt4, 10));
    repeat (3) step();
    drive(4, 1'b1, pb);
    step();
    chk("bi_rdy_run", 128'(bus4.in_ready), 128'd0);
    chk("bi_round",   128'(round4),        128'd5);
    sb_q.push_back(ref_enc(pb, kt4, 10));
    wait_out(4, 10, "bi_a", e);
    step();
    chk("bi_idle_rdy", 128'(bus4.in_ready), 128'd1);
    step();
    acc = cyc;
    drive(4, 1'b0, '0);
    chk("bi_b_busy",  128'(busy4),  128'd1);
    chk("bi_b_round", 128'(round4), 128'd1);
    wait_out(4, 10, "bi_b", e);
    step();

    // Asynchronous reset mid-operation
    accept(4, PT, C1);
    n = 0;
    while (round4 != 4'd5 && n < 20) begin
      step();
      n++;
    end
    rst_n = 1'b0;
    #1;
    chk_idle("arst");
    void'(sb_q.pop_back());
    step();
    step();
    rst_n = 1'b1;
    step();
    accept(4, PT, C1);
    wait_out(4, 10, "arst_c1", e);
    step();

    // Back-to-back random blocks
    for (int k = 0; k < 8; k++) begin
      p = rnd128();
      drive(4, 1'b1, p);
      n = 0;
      while (!bus4.in_ready && n < 40) begin
        step();
        n++;
      end
      step();
      if (k > 0) chk("b2b_gap", 128'(cyc - acc), 128'd12);
      acc = cyc;
      sb_q.push_back(ref_enc(p, kt4, 10));
      wait_out(4, 10, "b2b", e);
    end
    drive(4, 1'b0, '0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
